// File: rtl/urv_defs_pkg.sv
// urv_defs: shared CSR addresses, bit indices, cause codes and FSM encodings for the trap controller.
package urv_defs;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MIP = 12'h344;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MT = 7;
  localparam int IRQ_ME = 11;
  localparam logic [3:0] CAUSE_MEXT = 4'd11;
  localparam logic [3:0] CAUSE_MTIMER = 4'd7;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/urv_trap_ctrl.sv
// urv_trap_ctrl: machine-mode CSRs, interrupt/exception arbitration and trap redirect.
// Timer interrupt support is compiled in only when URV_TIMER_IRQ_EN is defined.
module urv_trap_ctrl
  import urv_defs::*;
#(
  parameter logic [31:0] g_mtvec_reset = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        x_valid_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_is_csr_i,
  input  logic [11:0] x_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        x_is_mret_i,
  input  logic        irq_i,
  input  logic        timer_tick_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        x_trap_o,
  output logic [31:0] x_trap_pc_o
);
  logic commit, run, exc_trap, ext_irq, tmr_irq, trap, csr_we, mret_en;
  logic st_mie, st_mpie, mie_meie, mie_mtie, mip_meip, mip_mtip, mcause_irq;
  logic [31:2] mtvec, mepc;
  logic [3:0] mcause_code;
  logic [31:0] wv;
  state_t state;
  logic unused;

  assign wv = x_csr_write_value_i;
  assign commit = x_valid_i & ~x_stall_i & ~x_kill_i;
  assign run = state == RUN;
  assign exc_trap = commit & x_exception_i;
  assign ext_irq = commit & st_mie & mie_meie & mip_meip;
  assign tmr_irq = commit & st_mie & mie_mtie & mip_mtip;
  assign trap = run & (exc_trap | ext_irq | tmr_irq);
  assign csr_we = run & commit & x_is_csr_i & ~trap;
  assign mret_en = run & commit & x_is_mret_i & ~trap;
  assign unused = ^{x_pc_i[1:0], wv[30:12], wv[10:8], wv[6:4], wv[2:0], timer_tick_i};

`ifdef URV_TIMER_IRQ_EN
  // A tick arriving with a clearing mip write keeps MTIP set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mip_mtip <= 1'b0;
      mie_mtie <= 1'b0;
    end else begin
      if (timer_tick_i) mip_mtip <= 1'b1;
      else if (csr_we && x_csr_sel_i == CSR_MIP && !wv[IRQ_MT]) mip_mtip <= 1'b0;
      if (csr_we && x_csr_sel_i == CSR_MIE) mie_mtie <= wv[IRQ_MT];
    end
  end
`else
  assign mip_mtip = 1'b0;
  assign mie_mtie = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      x_trap_o <= 1'b0;
      mip_meip <= 1'b0;
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      mie_meie <= 1'b0;
      mtvec <= g_mtvec_reset[31:2];
      mepc <= '0;
      mcause_irq <= 1'b0;
      mcause_code <= '0;
    end else begin
      mip_meip <= irq_i;
      x_trap_o <= trap;
      state <= trap ? FLUSH : RUN;
      if (trap) begin
        mepc <= x_pc_i[31:2];
        mcause_irq <= ~exc_trap;
        mcause_code <= exc_trap ? x_exception_cause_i : ext_irq ? CAUSE_MEXT : CAUSE_MTIMER;
        st_mpie <= st_mie;
        st_mie <= 1'b0;
      end else if (mret_en) begin
        st_mie <= st_mpie;
        st_mpie <= 1'b1;
      end else if (csr_we) begin
        if (x_csr_sel_i == CSR_MSTATUS) begin
          st_mie <= wv[MSTATUS_MIE];
          st_mpie <= wv[MSTATUS_MPIE];
        end
        if (x_csr_sel_i == CSR_MIE) mie_meie <= wv[IRQ_ME];
        if (x_csr_sel_i == CSR_MTVEC) mtvec <= wv[31:2];
        if (x_csr_sel_i == CSR_MEPC) mepc <= wv[31:2];
        if (x_csr_sel_i == CSR_MCAUSE) begin
          mcause_irq <= wv[31];
          mcause_code <= wv[3:0];
        end
      end
    end
  end

  always_comb begin
    csr_mstatus_o = '0;
    csr_mstatus_o[MSTATUS_MIE] = st_mie;
    csr_mstatus_o[MSTATUS_MPIE] = st_mpie;
    csr_mie_o = '0;
    csr_mie_o[IRQ_ME] = mie_meie;
    csr_mie_o[IRQ_MT] = mie_mtie;
    csr_mip_o = '0;
    csr_mip_o[IRQ_ME] = mip_meip;
    csr_mip_o[IRQ_MT] = mip_mtip;
    csr_mtvec_o = {mtvec, 2'b00};
    csr_mepc_o = {mepc, 2'b00};
    csr_mcause_o = {mcause_irq, 27'b0, mcause_code};
  end

  assign x_trap_pc_o = csr_mtvec_o;
endmodule

// File: tb/tb_urv_trap_ctrl.sv
// tb_urv_trap_ctrl: directed vector table, async-reset corner case and randomized run vs a CSR-level model.
module tb_urv_trap_ctrl;
`ifdef URV_TIMER_IRQ_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic v, s, k, csr, exc, mret, irq, tick;
  logic [31:0] pc, wv;
  logic [11:0] sel;
  logic [3:0] cause;
  logic [31:0] mstatus, mip, mie, mtvec, mepc, mcause, trap_pc;
  logic trap;
  int checks = 0, errors = 0;
  logic [31:0] m_ms, m_mie, m_mip, m_mtvec, m_mepc, m_mc;
  logic m_trap, m_flush;

  typedef struct {
    logic [31:0] pc;
    logic csr;
    logic [11:0] sel;
    logic [31:0] wv;
    logic exc;
    logic [3:0] cause;
    logic mret, irq, tick, stall, kill, valid, e_trap;
    logic [31:0] e_ms, e_mepc, e_mc;
  } vec_t;
  vec_t tbl[30];

  urv_trap_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(s), .x_kill_i(k), .x_valid_i(v), .x_pc_i(pc),
    .x_is_csr_i(csr), .x_csr_sel_i(sel), .x_csr_write_value_i(wv), .x_exception_i(exc),
    .x_exception_cause_i(cause), .x_is_mret_i(mret), .irq_i(irq), .timer_tick_i(tick),
    .csr_mstatus_o(mstatus), .csr_mip_o(mip), .csr_mie_o(mie), .csr_mtvec_o(mtvec),
    .csr_mepc_o(mepc), .csr_mcause_o(mcause), .x_trap_o(trap), .x_trap_pc_o(trap_pc)
  );

  always #5 clk = ~clk;

  function automatic vec_t r(logic [31:0] p, logic c, logic [11:0] sl, logic [31:0] w, logic e,
                             logic [3:0] ca, logic mr, logic iq, logic tk, logic st, logic kl,
                             logic vl, logic et, logic [31:0] ems, logic [31:0] emepc, logic [31:0] emc);
    vec_t x;
    x.pc = p; x.csr = c; x.sel = sl; x.wv = w; x.exc = e; x.cause = ca; x.mret = mr; x.irq = iq;
    x.tick = tk; x.stall = st; x.kill = kl; x.valid = vl; x.e_trap = et; x.e_ms = ems;
    x.e_mepc = emepc; x.e_mc = emc;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    v = 1; s = 0; k = 0; csr = 0; exc = 0; mret = 0; irq = 0; tick = 0;
    pc = 0; wv = 0; sel = 0; cause = 0;
  endtask

  task automatic model_reset();
    m_ms = 0; m_mie = 0; m_mip = 0; m_mtvec = 32'h100; m_mepc = 0; m_mc = 0;
    m_trap = 0; m_flush = 0;
  endtask

  task automatic model_step();
    logic c, run, ex, ei, ti, tr, we, mr, t7;
    c = v && !s && !k;
    run = !m_flush;
    ex = c && exc;
    ei = c && m_mie[11] && m_mip[11] && m_ms[3];
    ti = c && m_mie[7] && m_mip[7] && m_ms[3];
    tr = run && (ex || ei || ti);
    we = run && c && csr && !tr;
    mr = run && c && mret && !tr;
    t7 = TEN && (tick || (m_mip[7] && !(we && sel == 12'h344 && !wv[7])));
    if (tr) begin
      m_mepc = pc & ~32'h3;
      m_mc = ex ? {28'b0, cause} : ei ? 32'h8000_000B : 32'h8000_0007;
      m_ms = m_ms[3] ? 32'h80 : 32'h0;
    end else if (mr) m_ms = m_ms[7] ? 32'h88 : 32'h80;
    else if (we) begin
      if (sel == 12'h300) m_ms = wv & 32'h88;
      if (sel == 12'h304) m_mie = wv & (TEN ? 32'h880 : 32'h800);
      if (sel == 12'h305) m_mtvec = wv & ~32'h3;
      if (sel == 12'h341) m_mepc = wv & ~32'h3;
      if (sel == 12'h342) m_mc = wv & 32'h8000_000F;
    end
    m_mip = (irq ? 32'h800 : 32'h0) | (t7 ? 32'h80 : 32'h0);
    m_trap = tr;
    m_flush = tr;
  endtask

  task automatic compare();
    chk("trap", {31'b0, trap}, {31'b0, m_trap});
    chk("trap_pc", trap_pc, m_mtvec);
    chk("mstatus", mstatus, m_ms);
    chk("mie", mie, m_mie);
    chk("mip", mip, m_mip);
    chk("mtvec", mtvec, m_mtvec);
    chk("mepc", mepc, m_mepc);
    chk("mcause", mcause, m_mc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  initial begin
    logic [11:0] sels[8];
    sels = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340, 12'h7c0};
    tbl[0]  = r(32'h00, 1, 12'h304, 32'h800, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00, 32'h00, 32'h0);
    tbl[1]  = r(32'h04, 1, 12'h300, 32'h008, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h08, 32'h00, 32'h0);
    tbl[2]  = r(32'h3c, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h08, 32'h00, 32'h0);
    tbl[3]  = r(32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h80, 32'h40, 32'h8000_000B);
    tbl[4]  = r(32'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h80, 32'h40, 32'h8000_000B);
    tbl[5]  = r(32'h48, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 32'h88, 32'h40, 32'h8000_000B);
    tbl[6]  = r(32'h4c, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h80, 32'h4c, 32'h8000_000B);
    tbl[7]  = r(32'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h4c, 32'h8000_000B);
    tbl[8]  = r(32'h24, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 1, 32'h00, 32'h24, 32'h2);
    tbl[9]  = r(32'h28, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h00, 32'h24, 32'h2);
    tbl[10] = r(32'h2c, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 1, 1, 32'h00, 32'h2c, 32'h5);
    tbl[11] = r(32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00, 32'h2c, 32'h5);
    tbl[12] = r(32'h34, 1, 12'h300, 32'h008, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h08, 32'h2c, 32'h5);
    tbl[13] = r(32'h30, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 1, 1, 32'h80, 32'h30, 32'h3);
    tbl[14] = r(32'h34, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h30, 32'h3);
    tbl[15] = r(32'h38, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h88, 32'h30, 32'h3);
    tbl[16] = r(32'h60, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h88, 32'h30, 32'h3);
    tbl[17] = r(32'h64, 1, 12'h300, 32'h000, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h80, 32'h64, 32'h8000_000B);
    tbl[18] = r(32'h68, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h64, 32'h8000_000B);
    tbl[19] = r(32'h6c, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[20] = r(32'h70, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[21] = r(32'h70, 0, 0, 0, 1, 4, 0, 1, 0, 1, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[22] = r(32'h70, 1, 12'h300, 32'h000, 0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[23] = r(32'h74, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[24] = r(32'h78, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[25] = r(32'h7c, 1, 12'h304, 32'h880, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[26] = r(32'h80, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[27] = TEN ? r(32'h84, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h84, 32'h8000_0007)
                  : r(32'h84, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[28] = TEN ? r(32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h84, 32'h8000_0007)
                  : r(32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    tbl[29] = TEN ? r(32'h8c, 1, 12'h344, 32'h000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h84, 32'h8000_0007)
                  : r(32'h8c, 1, 12'h344, 32'h000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 32'h64, 32'h8000_000B);
    idle();
    model_reset();
    #22;
    chk("rst.mtvec", mtvec, 32'h100);
    chk("rst.trap", {31'b0, trap}, 32'h0);
    chk("rst.csrs", mstatus | mie | mip | mepc | mcause, 32'h0);
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      pc = tbl[i].pc; csr = tbl[i].csr; sel = tbl[i].sel; wv = tbl[i].wv; exc = tbl[i].exc;
      cause = tbl[i].cause; mret = tbl[i].mret; irq = tbl[i].irq; tick = tbl[i].tick;
      s = tbl[i].stall; k = tbl[i].kill; v = tbl[i].valid;
      step();
      chk($sformatf("row%0d.trap", i), {31'b0, trap}, {31'b0, tbl[i].e_trap});
      chk($sformatf("row%0d.mstatus", i), mstatus, tbl[i].e_ms);
      chk($sformatf("row%0d.mepc", i), mepc, tbl[i].e_mepc);
      chk($sformatf("row%0d.mcause", i), mcause, tbl[i].e_mc);
    end
    chk("end.mip", mip, 32'h0);
    chk("end.mie", mie, TEN ? 32'h880 : 32'h800);
    // Reset landing in the middle of a trap pulse must clear everything at once.
    idle();
    pc = 32'h90; exc = 1; cause = 4'd1;
    step();
    chk("pulse.trap", {31'b0, trap}, 32'h1);
    idle();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst.trap", {31'b0, trap}, 32'h0);
    chk("arst.mepc", mepc, 32'h0);
    chk("arst.mcause", mcause, 32'h0);
    chk("arst.mtvec", mtvec, 32'h100);
    #3 rst_n = 1;
    step();
    for (int i = 0; i < 600; i++) begin
      idle();
      v = ($urandom_range(7) != 0);
      s = ($urandom_range(7) == 0);
      k = ($urandom_range(15) == 0);
      pc = $urandom;
      irq = (i % 16) < 9 ? $urandom_range(1) == 1 : (i % 3 == 0);
      tick = ($urandom_range(7) == 0);
      exc = ($urandom_range(7) == 0);
      cause = 4'($urandom);
      case ($urandom_range(3))
        0: begin csr = 1; sel = sels[$urandom_range(7)]; wv = $urandom; end
        1: mret = ($urandom_range(1) == 1);
        default: ;
      endcase
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
